// File: rtl/dsp_pkg.sv
// Shared constants for the dsp MAC slice: opMode bit positions and X/Z mux encodings.
package dsp_pkg;

    localparam int unsigned OpmXLsb     = 0;
    localparam int unsigned OpmZLsb     = 2;
    localparam int unsigned OpmPreSel   = 4;
    localparam int unsigned OpmCarry    = 5;
    localparam int unsigned OpmPreSub   = 6;
    localparam int unsigned OpmPostSub  = 7;

    typedef enum logic [1:0] {
        XZero   = 2'd0,
        XMul    = 2'd1,
        XP      = 2'd2,
        XConcat = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        ZZero = 2'd0,
        ZPcin = 2'd1,
        ZP    = 2'd2,
        ZC    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/dsp_reg_mux.sv
// One pipeline stage: a clock-enabled register with sync reset, or a plain wire when SEL = 0.
module reg_mux #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned SEL   = 1
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (SEL != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (ce) begin
                q <= d;
            end
        end
    end else begin : g_wire
        // Bypassed stages ignore clock, enable and reset.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, ce, rst};
        assign q = d;
    end

endmodule

// File: rtl/dsp.sv
// Pipelined 18x18 MAC slice: pre-adder on D/B, unsigned multiply by A, 48-bit post-adder.
module dsp
    import dsp_pkg::*;
#(
    parameter int unsigned A0REG       = 0,
    parameter int unsigned A1REG       = 1,
    parameter int unsigned B0REG       = 0,
    parameter int unsigned B1REG       = 1,
    parameter int unsigned CREG        = 1,
    parameter int unsigned DREG        = 1,
    parameter int unsigned MREG        = 1,
    parameter int unsigned PREG        = 1,
    parameter int unsigned CARRYINREG  = 1,
    parameter int unsigned CARRYOUTREG = 1,
    parameter int unsigned OPMODEREG   = 1,
    parameter string       CARRYINSEL  = "OPMODE5",
    parameter string       B_INPUT     = "DIRECT"
) (
    input  logic        clk,
    input  logic        rstA,
    input  logic        rstB,
    input  logic        rstC,
    input  logic        rstCarryIn,
    input  logic        rstD,
    input  logic        rstM,
    input  logic        rstOpMode,
    input  logic        rstP,
    input  logic [7:0]  opMode,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CECarryIn,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEOpMode,
    input  logic        CEP,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic        carryIn,
    input  logic [17:0] BCIn,
    input  logic [47:0] PCIn,
    output logic [17:0] BCOut,
    output logic [47:0] PCOut,
    output logic [47:0] P,
    output logic [35:0] M,
    output logic        carryOut,
    output logic        carryOutF
);

    logic [7:0]  opmode_q;
    logic [17:0] a0_q, a1_q, b_src, b0_q, b1_d, b1_q, d_q, pre_sum;
    logic [47:0] c_q, p_q, x_mux, z_mux;
    logic [35:0] m_d, m_q;
    logic        cyi_d, cyi_q, cyo_q;
    logic [48:0] post_sum;

    if (B_INPUT == "DIRECT") begin : g_b_direct
        assign b_src = B;
    end else if (B_INPUT == "CASCADE") begin : g_b_cascade
        assign b_src = BCIn;
    end else begin : g_b_zero
        assign b_src = '0;
    end

    if (CARRYINSEL == "OPMODE5") begin : g_cy_opmode
        assign cyi_d = opmode_q[OpmCarry];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cy_port
        assign cyi_d = carryIn;
    end else begin : g_cy_zero
        assign cyi_d = 1'b0;
    end

    // Inputs that only some parameterisations consume.
    logic unused_inputs;
    assign unused_inputs = ^{B, BCIn, carryIn};

    reg_mux #(.WIDTH(8), .SEL(OPMODEREG)) u_opmode (
        .clk(clk), .ce(CEOpMode), .rst(rstOpMode), .d(opMode), .q(opmode_q)
    );
    reg_mux #(.WIDTH(18), .SEL(A0REG)) u_a0 (
        .clk(clk), .ce(CEA), .rst(rstA), .d(A), .q(a0_q)
    );
    reg_mux #(.WIDTH(18), .SEL(A1REG)) u_a1 (
        .clk(clk), .ce(CEA), .rst(rstA), .d(a0_q), .q(a1_q)
    );
    reg_mux #(.WIDTH(18), .SEL(B0REG)) u_b0 (
        .clk(clk), .ce(CEB), .rst(rstB), .d(b_src), .q(b0_q)
    );
    reg_mux #(.WIDTH(18), .SEL(DREG)) u_d (
        .clk(clk), .ce(CED), .rst(rstD), .d(D), .q(d_q)
    );
    reg_mux #(.WIDTH(48), .SEL(CREG)) u_c (
        .clk(clk), .ce(CEC), .rst(rstC), .d(C), .q(c_q)
    );

    assign pre_sum = opmode_q[OpmPreSub] ? (d_q - b0_q) : (d_q + b0_q);
    assign b1_d    = opmode_q[OpmPreSel] ? pre_sum : b0_q;

    reg_mux #(.WIDTH(18), .SEL(B1REG)) u_b1 (
        .clk(clk), .ce(CEB), .rst(rstB), .d(b1_d), .q(b1_q)
    );

    assign m_d = 36'(b1_q) * 36'(a1_q);

    reg_mux #(.WIDTH(36), .SEL(MREG)) u_m (
        .clk(clk), .ce(CEM), .rst(rstM), .d(m_d), .q(m_q)
    );
    reg_mux #(.WIDTH(1), .SEL(CARRYINREG)) u_cyi (
        .clk(clk), .ce(CECarryIn), .rst(rstCarryIn), .d(cyi_d), .q(cyi_q)
    );

    always_comb begin
        x_mux = '0;
        unique case (x_sel_e'(opmode_q[OpmXLsb +: 2]))
            XZero:   x_mux = '0;
            XMul:    x_mux = {12'd0, m_q};
            XP:      x_mux = p_q;
            XConcat: x_mux = {d_q[11:0], a1_q, b1_q};
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        unique case (z_sel_e'(opmode_q[OpmZLsb +: 2]))
            ZZero:   z_mux = '0;
            ZPcin:   z_mux = PCIn;
            ZP:      z_mux = p_q;
            ZC:      z_mux = c_q;
            default: z_mux = '0;
        endcase
    end

    // Bit 48 is the carry when adding and the borrow when subtracting.
    always_comb begin
        post_sum = '0;
        if (opmode_q[OpmPostSub]) begin
            post_sum = {1'b0, z_mux} - {1'b0, x_mux} - 49'(cyi_q);
        end else begin
            post_sum = {1'b0, z_mux} + {1'b0, x_mux} + 49'(cyi_q);
        end
    end

    reg_mux #(.WIDTH(48), .SEL(PREG)) u_p (
        .clk(clk), .ce(CEP), .rst(rstP), .d(post_sum[47:0]), .q(p_q)
    );
    reg_mux #(.WIDTH(1), .SEL(CARRYOUTREG)) u_cyo (
        .clk(clk), .ce(CECarryIn), .rst(rstCarryIn), .d(post_sum[48]), .q(cyo_q)
    );

    assign BCOut     = b1_q;
    assign M         = m_q;
    assign P         = p_q;
    assign PCOut     = p_q;
    assign carryOut  = cyo_q;
    assign carryOutF = cyo_q;

endmodule

// File: tb/tb_dsp.sv
// Scoreboard bench for dsp: stimulus queues expected outputs, a negedge monitor compares them.
module tb_dsp;

    logic        clk = 1'b0;
    logic        rstA, rstB, rstC, rstCarryIn, rstD, rstM, rstOpMode, rstP;
    logic [7:0]  opMode;
    logic        CEA, CEB, CEC, CECarryIn, CED, CEM, CEOpMode, CEP;
    logic [17:0] A, B, D, BCIn;
    logic [47:0] C, PCIn;
    logic        carryIn;
    logic [17:0] BCOut;
    logic [47:0] PCOut, P;
    logic [35:0] M;
    logic        carryOut, carryOutF;

    dsp u_dut (
        .clk(clk), .rstA(rstA), .rstB(rstB), .rstC(rstC), .rstCarryIn(rstCarryIn),
        .rstD(rstD), .rstM(rstM), .rstOpMode(rstOpMode), .rstP(rstP), .opMode(opMode),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CECarryIn(CECarryIn), .CED(CED), .CEM(CEM),
        .CEOpMode(CEOpMode), .CEP(CEP), .A(A), .B(B), .D(D), .C(C), .carryIn(carryIn),
        .BCIn(BCIn), .PCIn(PCIn), .BCOut(BCOut), .PCOut(PCOut), .P(P), .M(M),
        .carryOut(carryOut), .carryOutF(carryOutF)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [17:0] bc;
        logic [35:0] m;
        logic [47:0] p;
        logic        co;
        bit          chk_bc;
        bit          chk_m;
        bit          chk_p;
        bit          chk_co;
    } exp_t;

    exp_t exp_q[$];
    bit   sample = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: consumes one expectation whenever the stimulus marks the outputs as presented.
    always @(negedge clk) begin
        if (sample) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL scoreboard: got empty queue, expected an entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_bc) chk({e.name, ".BCOut"}, 48'(BCOut), 48'(e.bc));
                if (e.chk_m)  chk({e.name, ".M"}, 48'(M), 48'(e.m));
                if (e.chk_p) begin
                    chk({e.name, ".P"}, P, e.p);
                    chk({e.name, ".PCOut"}, PCOut, e.p);
                end
                if (e.chk_co) begin
                    chk({e.name, ".carryOut"}, 48'(carryOut), 48'(e.co));
                    chk({e.name, ".carryOutF"}, 48'(carryOutF), 48'(e.co));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [17:0] bc, input logic [35:0] m,
                              input logic [47:0] p, input logic co, input bit cbc,
                              input bit cm, input bit cp, input bit cco);
        exp_t e;
        e.name = nm; e.bc = bc; e.m = m; e.p = p; e.co = co;
        e.chk_bc = cbc; e.chk_m = cm; e.chk_p = cp; e.chk_co = cco;
        exp_q.push_back(e);
        sample = 1'b1;
        @(negedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic set_rst(input logic v);
        {rstA, rstB, rstC, rstCarryIn, rstD, rstM, rstOpMode, rstP} = {8{v}};
    endtask

    task automatic set_ce(input logic [7:0] v);
        {CEA, CEB, CEC, CECarryIn, CED, CEM, CEOpMode, CEP} = v;
    endtask

    initial begin
        set_rst(1'b1);
        set_ce(8'($urandom));
        opMode  = 8'($urandom);
        A       = 18'($urandom);
        B       = 18'($urandom);
        D       = 18'($urandom);
        BCIn    = 18'($urandom);
        C       = {16'($urandom), 32'($urandom)};
        PCIn    = {16'($urandom), 32'($urandom)};
        carryIn = 1'($urandom);
        step(1);
        expect_out("reset", 18'd0, 36'd0, 48'd0, 1'b0, 1, 1, 1, 1);

        set_rst(1'b0);
        set_ce(8'hFF);
        A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350; PCIn = 48'd0; carryIn = 1'b0;
        opMode = 8'b1101_1101;
        step(4);
        expect_out("c_minus_m", 18'h0F, 36'h12C, 48'h32, 1'b0, 1, 1, 1, 1);

        opMode = 8'b0001_0000;
        step(3);
        expect_out("preadd_zero", 18'h23, 36'h2BC, 48'h0, 1'b0, 1, 1, 1, 1);

        opMode = 8'b0000_1010;
        step(3);
        expect_out("p_plus_p", 18'h0A, 36'hC8, 48'h0, 1'b0, 1, 1, 1, 1);

        A = 18'd5; B = 18'd6; PCIn = 48'd3000;
        opMode = 8'b1010_0111;
        step(3);
        expect_out("pcin_minus_cat", 18'd6, 36'h1E, 48'hFE6F_FFEC_0BB1, 1'b1, 1, 1, 1, 1);

        // P frozen while the rest of the pipe follows the new opMode.
        CEP = 1'b0;
        opMode = 8'b0000_0000;
        step(3);
        expect_out("cep_hold", 18'd6, 36'h1E, 48'hFE6F_FFEC_0BB1, 1'b0, 1, 1, 1, 1);

        rstP = 1'b1;
        step(1);
        expect_out("rstp_only", 18'd6, 36'h1E, 48'h0, 1'b0, 1, 1, 1, 1);
        rstP = 1'b0;

        step(1);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
